// File: rtl/pc_unit.sv
// Program-counter stage: PC register, +INC successor, redirect priority,
// fetch stall and optional return-address stack (macro PC_UNIT_RAS_EN).
// Ports: clk, clrn (sync active-high reset), stall, exc, br_taken/br_target,
//        jump/jump_target, call, ret -> pc, pc4, pc_valid, misalign, ras_empty.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      INC       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0180),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             stall,
    input  logic             exc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic             pc_valid,
    output logic             misalign,
    output logic             ras_empty
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic [WIDTH-1:0] ret_tgt;

    assign pc        = pc_q;
    assign pc4       = pc_q + WIDTH'(INC);
    assign pc_valid  = pc_valid_q;
    assign misalign  = pc_q[1:0] != 2'b00;

`ifdef PC_UNIT_RAS_EN
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ras_ok, ras_hit, push, pop, swap;

    assign ras_ok  = !exc && !br_taken;
    assign ras_hit = cnt_q != '0;
    // ret+call on a non-empty stack replaces the top instead of pop+push
    assign swap    = ras_ok && ret && call && ras_hit;
    assign push    = ras_ok && call && (jump || ret) && !swap;
    assign pop     = ras_ok && ret && !call && ras_hit;
    assign ret_tgt = ras_hit ? ras_q[top_q] : jump_target;
    assign ras_empty = !ras_hit;

    always_comb begin
        ras_d = ras_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (swap) begin
            ras_d[top_q] = pc4;
        end else if (push) begin
            // circular: when full the new top lands on the oldest slot
            top_d        = top_q + PW'(1);
            ras_d[top_d] = pc4;
            if (cnt_q != CW'(RAS_DEPTH))
                cnt_d = cnt_q + CW'(1);
        end else if (pop) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn)
            ras_q <= ras_d;
    end
`else
    logic unused_ras;

    assign unused_ras = call ^ RAS_DEPTH[0];
    assign ret_tgt    = jump_target;
    assign ras_empty  = 1'b1;
`endif

    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        if (exc)
            pc_d = EXC_VEC;
        else if (br_taken)
            pc_d = br_target;
        else if (ret)
            pc_d = ret_tgt;
        else if (jump)
            pc_d = jump_target;
        else if (!stall)
            pc_d = pc4;
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: reference model feeds a scoreboard queue,
// DUT outputs are popped and compared one cycle after each stimulus.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        clrn, stall, exc, br_taken, jump, call, ret;
    logic [31:0] br_target, jump_target;
    logic [31:0] pc, pc4;
    logic        pc_valid, misalign, ras_empty;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] pc4;
        logic        mis;
        logic        empty;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ras[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk        (clk),
        .clrn       (clrn),
        .stall      (stall),
        .exc        (exc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jump       (jump),
        .jump_target(jump_target),
        .call       (call),
        .ret        (ret),
        .pc         (pc),
        .pc4        (pc4),
        .pc_valid   (pc_valid),
        .misalign   (misalign),
        .ras_empty  (ras_empty)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] tgt, seq;
        logic        ok;
        exp_t        e;
        seq = m_pc + 32'd4;
        if (clrn) begin
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_ras.delete();
        end else begin
            tgt = jump_target;
            ok  = !exc && !br_taken;
`ifdef PC_UNIT_RAS_EN
            if (m_ras.size() > 0)
                tgt = m_ras[m_ras.size()-1];
            if (ok && ret && call) begin
                if (m_ras.size() > 0)
                    m_ras[m_ras.size()-1] = seq;
                else
                    m_ras.push_back(seq);
            end else if (ok && call && jump) begin
                m_ras.push_back(seq);
                if (m_ras.size() > 4)
                    void'(m_ras.pop_front());
            end else if (ok && ret && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
`else
            ok = ok;
`endif
            if (exc)
                m_pc = 32'h180;
            else if (br_taken)
                m_pc = br_target;
            else if (ret)
                m_pc = tgt;
            else if (jump)
                m_pc = jump_target;
            else if (!stall)
                m_pc = seq;
            m_valid = 1'b1;
        end
        e.pc    = m_pc;
        e.valid = m_valid;
        e.pc4   = m_pc + 32'd4;
        e.mis   = m_pc[1:0] != 2'b00;
        e.empty = m_ras.size() == 0;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic st, input logic ex,
                         input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt,
                         input logic cl, input logic rt);
        exp_t e;
        clrn        = r;
        stall       = st;
        exc         = ex;
        br_taken    = br;
        br_target   = bt;
        jump        = jp;
        jump_target = jt;
        call        = cl;
        ret         = rt;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_valid", 32'(pc_valid), 32'(e.valid));
        chk("pc4", pc4, e.pc4);
        chk("misalign", 32'(misalign), 32'(e.mis));
        chk("ras_empty", 32'(ras_empty), 32'(e.empty));
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        clrn = 1; stall = 0; exc = 0; br_taken = 0; jump = 0;
        call = 0; ret = 0; br_target = 0; jump_target = 0;
        m_pc = 0; m_valid = 0;
        #2;
        // reset, then free run
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        // stall holds, redirect beats stall
        repeat (3) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 32'h100, 0, 0, 0, 0);
        // priority
        drive(0, 0, 1, 1, 32'h40, 1, 32'h80, 0, 0);
        drive(0, 0, 0, 1, 32'h40, 1, 32'h80, 0, 0);
        // wrap and misalign
        drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        idle();
        drive(0, 0, 0, 0, 0, 1, 32'h102, 0, 0);
        idle();
        drive(0, 0, 0, 0, 0, 1, 32'h200, 0, 0);
        // ret on empty stack
        drive(0, 0, 0, 0, 0, 0, 32'h300, 0, 1);
        // five calls, five returns
        drive(0, 0, 0, 0, 0, 1, 32'h10, 0, 0);
        for (int i = 2; i <= 6; i++)
            drive(0, 0, 0, 0, 0, 1, 32'(i * 16), 1, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 32'hDEAD, 0, 1);
        // stall does not block push; ret+call swap; exc blocks push
        drive(0, 1, 0, 0, 0, 1, 32'h500, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 32'h600, 1, 1);
        drive(0, 0, 1, 0, 0, 1, 32'h640, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 32'h700, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 32'h704, 0, 1);
        // reset mid-stack discards pending call
        drive(0, 0, 0, 0, 0, 1, 32'h800, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h900, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 32'hA00, 1, 0);
        drive(1, 1, 0, 0, 0, 1, 32'hB00, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 32'h400, 0, 1);
        // random mix
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(39) == 0,
                  $urandom_range(3) == 0,
                  $urandom_range(15) == 0,
                  $urandom_range(7) == 0,
                  $urandom & 32'h0000_FFFC,
                  $urandom_range(5) == 0,
                  $urandom & 32'h0000_FFFF,
                  $urandom_range(2) == 0,
                  $urandom_range(7) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
